// File: rtl/produto_escalar_pkg.sv
// Shared sizes and FSM state type for the dot-product sequencer.
package produto_escalar_pkg;

  localparam int unsigned N_ELEMENTOS       = 8;
  localparam int unsigned LARGURA_OPERANDO  = 32;
  localparam int unsigned LARGURA_RESULTADO = 64;
  localparam int unsigned LARGURA_INDICE    = $clog2(N_ELEMENTOS);

  typedef enum logic [1:0] {
    CARREGANDO = 2'd0,
    DISPARO    = 2'd1,
    LIBERANDO  = 2'd2,
    ENTREGANDO = 2'd3
  } seq_estado_t;

endpackage

// File: rtl/produto_escalar_banco_operandos.sv
// Eight-entry a/b operand bank: one sequential write per cycle, all entries visible in parallel.
module produto_escalar_banco_operandos
  import produto_escalar_pkg::*;
(
  input  logic                                            clk_i,
  input  logic                                            rst_n,
  input  logic                                            escrita,
  input  logic [LARGURA_INDICE-1:0]                       indice,
  input  logic [LARGURA_OPERANDO-1:0]                     dado_a,
  input  logic [LARGURA_OPERANDO-1:0]                     dado_b,
  output logic [N_ELEMENTOS-1:0][LARGURA_OPERANDO-1:0]    banco_a,
  output logic [N_ELEMENTOS-1:0][LARGURA_OPERANDO-1:0]    banco_b
);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      banco_a <= '0;
      banco_b <= '0;
    end else if (escrita) begin
      banco_a[indice] <= dado_a;
      banco_b[indice] <= dado_b;
    end
  end

endmodule

// File: rtl/produto_escalar_sequenciador.sv
// Initiator-side sequencer for the 8x32 dot-product engine (four-phase iniciar/concluido).
// Optional watchdog enabled by defining PRODUTO_ESCALAR_TIMEOUT_EN.
module produto_escalar_sequenciador
  import produto_escalar_pkg::*;
#(
  parameter int unsigned TIMEOUT_CICLOS = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LARGURA_OPERANDO-1:0]   in_a,
  input  logic [LARGURA_OPERANDO-1:0]   in_b,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LARGURA_RESULTADO-1:0]  out_resultado,
  output logic                          out_erro,
  output logic                          ocupado,
  output logic [LARGURA_OPERANDO-1:0]   pe_a0,
  output logic [LARGURA_OPERANDO-1:0]   pe_a1,
  output logic [LARGURA_OPERANDO-1:0]   pe_a2,
  output logic [LARGURA_OPERANDO-1:0]   pe_a3,
  output logic [LARGURA_OPERANDO-1:0]   pe_a4,
  output logic [LARGURA_OPERANDO-1:0]   pe_a5,
  output logic [LARGURA_OPERANDO-1:0]   pe_a6,
  output logic [LARGURA_OPERANDO-1:0]   pe_a7,
  output logic [LARGURA_OPERANDO-1:0]   pe_b0,
  output logic [LARGURA_OPERANDO-1:0]   pe_b1,
  output logic [LARGURA_OPERANDO-1:0]   pe_b2,
  output logic [LARGURA_OPERANDO-1:0]   pe_b3,
  output logic [LARGURA_OPERANDO-1:0]   pe_b4,
  output logic [LARGURA_OPERANDO-1:0]   pe_b5,
  output logic [LARGURA_OPERANDO-1:0]   pe_b6,
  output logic [LARGURA_OPERANDO-1:0]   pe_b7,
  output logic                          pe_iniciar,
  input  logic                          pe_concluido,
  input  logic [LARGURA_RESULTADO-1:0]  pe_resultado
);

  if (TIMEOUT_CICLOS < 2) begin : g_timeout_invalido
    $error("TIMEOUT_CICLOS must be at least 2");
  end

  seq_estado_t                                     estado_q, estado_d;
  logic [LARGURA_INDICE-1:0]                       contador_q, contador_d;
  logic                                            iniciar_d;
  logic                                            valid_d;
  logic [LARGURA_RESULTADO-1:0]                    resultado_d;
  logic                                            escrita;
  logic [N_ELEMENTOS-1:0][LARGURA_OPERANDO-1:0]    banco_a, banco_b;

`ifdef PRODUTO_ESCALAR_TIMEOUT_EN
  localparam int unsigned LARGURA_WD = $clog2(TIMEOUT_CICLOS + 1);
  logic                  erro_q, erro_d;
  logic [LARGURA_WD-1:0] wd_q, wd_d;
  logic                  wd_expirou;

  assign wd_expirou = (wd_q == LARGURA_WD'(TIMEOUT_CICLOS - 1));
  assign out_erro   = erro_q;
`else
  assign out_erro   = 1'b0;
`endif

  // Stream handshakes decoded from the state register only.
  assign in_ready = (estado_q == CARREGANDO);
  assign ocupado  = (estado_q != CARREGANDO);

  produto_escalar_banco_operandos u_banco (
    .clk_i   (clk_i),
    .rst_n   (rst_n),
    .escrita (escrita),
    .indice  (contador_q),
    .dado_a  (in_a),
    .dado_b  (in_b),
    .banco_a (banco_a),
    .banco_b (banco_b)
  );

  assign pe_a0 = banco_a[0];
  assign pe_a1 = banco_a[1];
  assign pe_a2 = banco_a[2];
  assign pe_a3 = banco_a[3];
  assign pe_a4 = banco_a[4];
  assign pe_a5 = banco_a[5];
  assign pe_a6 = banco_a[6];
  assign pe_a7 = banco_a[7];
  assign pe_b0 = banco_b[0];
  assign pe_b1 = banco_b[1];
  assign pe_b2 = banco_b[2];
  assign pe_b3 = banco_b[3];
  assign pe_b4 = banco_b[4];
  assign pe_b5 = banco_b[5];
  assign pe_b6 = banco_b[6];
  assign pe_b7 = banco_b[7];

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      estado_q      <= CARREGANDO;
      contador_q    <= '0;
      pe_iniciar    <= 1'b0;
      out_valid     <= 1'b0;
      out_resultado <= '0;
`ifdef PRODUTO_ESCALAR_TIMEOUT_EN
      erro_q        <= 1'b0;
      wd_q          <= '0;
`endif
    end else begin
      estado_q      <= estado_d;
      contador_q    <= contador_d;
      pe_iniciar    <= iniciar_d;
      out_valid     <= valid_d;
      out_resultado <= resultado_d;
`ifdef PRODUTO_ESCALAR_TIMEOUT_EN
      erro_q        <= erro_d;
      wd_q          <= wd_d;
`endif
    end
  end

  // Next state plus next values of every registered output.
  always_comb begin
    estado_d    = estado_q;
    contador_d  = contador_q;
    iniciar_d   = pe_iniciar;
    valid_d     = out_valid;
    resultado_d = out_resultado;
    escrita     = 1'b0;
`ifdef PRODUTO_ESCALAR_TIMEOUT_EN
    erro_d      = erro_q;
    wd_d        = wd_q;
`endif
    case (estado_q)
      CARREGANDO: begin
        if (in_valid) begin
          escrita = 1'b1;
          if (contador_q == LARGURA_INDICE'(N_ELEMENTOS - 1)) begin
            contador_d = '0;
            iniciar_d  = 1'b1;
            estado_d   = DISPARO;
`ifdef PRODUTO_ESCALAR_TIMEOUT_EN
            wd_d       = '0;
`endif
          end else begin
            contador_d = contador_q + LARGURA_INDICE'(1);
          end
        end
      end
      DISPARO: begin
        if (pe_concluido) begin
          resultado_d = pe_resultado;
          iniciar_d   = 1'b0;
          estado_d    = LIBERANDO;
`ifdef PRODUTO_ESCALAR_TIMEOUT_EN
          wd_d        = '0;
        end else if (wd_expirou) begin
          resultado_d = '0;
          iniciar_d   = 1'b0;
          erro_d      = 1'b1;
          estado_d    = LIBERANDO;
          wd_d        = '0;
        end else begin
          wd_d        = wd_q + LARGURA_WD'(1);
`endif
        end
      end
      LIBERANDO: begin
        if (!pe_concluido) begin
          valid_d  = 1'b1;
          estado_d = ENTREGANDO;
`ifdef PRODUTO_ESCALAR_TIMEOUT_EN
        end else if (wd_expirou) begin
          valid_d  = 1'b1;
          erro_d   = 1'b1;
          estado_d = ENTREGANDO;
        end else begin
          wd_d     = wd_q + LARGURA_WD'(1);
`endif
        end
      end
      ENTREGANDO: begin
        if (out_ready) begin
          valid_d  = 1'b0;
          estado_d = CARREGANDO;
`ifdef PRODUTO_ESCALAR_TIMEOUT_EN
          erro_d   = 1'b0;
`endif
        end
      end
      default: begin
        estado_d   = CARREGANDO;
        contador_d = '0;
        iniciar_d  = 1'b0;
        valid_d    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_produto_escalar_sequenciador.sv
// Self-checking bench for produto_escalar_sequenciador with a behavioural engine attached.
// Timeout scenario runs only when PRODUTO_ESCALAR_TIMEOUT_EN is defined.
module tb_produto_escalar_sequenciador;

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_erro, ocupado;
  logic [31:0] in_a, in_b;
  logic [63:0] out_resultado;
  logic [31:0] pe_a0, pe_a1, pe_a2, pe_a3, pe_a4, pe_a5, pe_a6, pe_a7;
  logic [31:0] pe_b0, pe_b1, pe_b2, pe_b3, pe_b4, pe_b5, pe_b6, pe_b7;
  logic        pe_iniciar, pe_concluido;
  logic [63:0] pe_resultado;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit engine_ativo = 1'b1;
  int eng_cnt;

  logic [31:0] pa [8];
  logic [31:0] pb [8];

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  produto_escalar_sequenciador #(.TIMEOUT_CICLOS(16)) dut (
    .clk_i(clk_i), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_resultado(out_resultado),
    .out_erro(out_erro), .ocupado(ocupado),
    .pe_a0(pe_a0), .pe_a1(pe_a1), .pe_a2(pe_a2), .pe_a3(pe_a3),
    .pe_a4(pe_a4), .pe_a5(pe_a5), .pe_a6(pe_a6), .pe_a7(pe_a7),
    .pe_b0(pe_b0), .pe_b1(pe_b1), .pe_b2(pe_b2), .pe_b3(pe_b3),
    .pe_b4(pe_b4), .pe_b5(pe_b5), .pe_b6(pe_b6), .pe_b7(pe_b7),
    .pe_iniciar(pe_iniciar), .pe_concluido(pe_concluido), .pe_resultado(pe_resultado)
  );

  always_comb begin
    pa = '{pe_a0, pe_a1, pe_a2, pe_a3, pe_a4, pe_a5, pe_a6, pe_a7};
    pb = '{pe_b0, pe_b1, pe_b2, pe_b3, pe_b4, pe_b5, pe_b6, pe_b7};
  end

  function automatic logic [63:0] soma_produtos(input logic [31:0] a [8], input logic [31:0] b [8]);
    longint s = 0;
    for (int k = 0; k < 8; k++) s += longint'($signed(a[k])) * longint'($signed(b[k]));
    return 64'(s);
  endfunction

  // Engine: raises concluido 9 edges after seeing iniciar, drops it once iniciar falls.
  always @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      pe_concluido <= 1'b0;
      pe_resultado <= '0;
      eng_cnt      <= 0;
    end else if (engine_ativo) begin
      if (pe_iniciar && !pe_concluido) begin
        if (eng_cnt == 8) begin
          pe_concluido <= 1'b1;
          pe_resultado <= soma_produtos(pa, pb);
          eng_cnt      <= 0;
        end else begin
          eng_cnt <= eng_cnt + 1;
        end
      end else if (!pe_iniciar && pe_concluido) begin
        pe_concluido <= 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Loads eight pairs; modo 0 = every cycle, 1 = every other cycle, 2 = random gaps.
  task automatic envia_job(input logic [31:0] a [8], input logic [31:0] b [8], input int modo,
                           output int n0);
    int  k = 0;
    bit  alterna = 1'b0;
    bit  iniciar_cedo = 1'b0;
    bit  fire;
    int  guarda = 0;
    while (k < 8 && guarda < 200) begin
      guarda++;
      iniciar_cedo |= pe_iniciar;
      if (modo == 0 || (modo == 1 && !alterna) || (modo == 2 && $urandom_range(0, 1) == 1)) begin
        in_valid = 1'b1;
        in_a     = a[k];
        in_b     = b[k];
      end else begin
        in_valid = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
      end
      alterna = ~alterna;
      fire = in_valid && in_ready;
      @(negedge clk_i);
      if (fire) k++;
    end
    in_valid = 1'b0;
    n0 = cyc;
    check("load_complete", 64'(k), 64'd8);
    check("iniciar_before_8th", 64'(iniciar_cedo), 64'd0);
  endtask

  task automatic espera_valid(output int cyc_valid);
    int guarda = 0;
    while (!out_valid && guarda < 300) begin
      guarda++;
      @(negedge clk_i);
    end
    cyc_valid = cyc;
    check("out_valid_seen", 64'(out_valid), 64'd1);
  endtask

  // Holds out_ready low for 'hold' cycles, then accepts and checks back-to-back readiness.
  task automatic entrega(input string tag, input logic [63:0] exp, input logic erro_exp, input int hold);
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      check({tag, "_held_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_held_result"}, out_resultado, exp);
      @(negedge clk_i);
    end
    check({tag, "_result"}, out_resultado, exp);
    check({tag, "_erro"}, 64'(out_erro), 64'(erro_exp));
    out_ready = 1'b1;
    @(negedge clk_i);
    check({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
    check({tag, "_in_ready_next"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [31:0] a [8];
    logic [31:0] b [8];
    logic [63:0] esperado;
    int n0, nv, cnt;

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk_i);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_iniciar", 64'(pe_iniciar), 64'd0);
    check("rst_ocupado", 64'(ocupado), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    @(negedge clk_i);

    // Basic job: a=1..8, b=1, latency and single-cycle out_valid.
    for (int k = 0; k < 8; k++) begin a[k] = 32'(k + 1); b[k] = 32'd1; end
    envia_job(a, b, 0, n0);
    check("basic_iniciar_up", 64'(pe_iniciar), 64'd1);
    check("basic_ocupado", 64'(ocupado), 64'd1);
    check("basic_pe_a3", 64'(pe_a3), 64'd4);
    check("basic_pe_b7", 64'(pe_b7), 64'd1);
    espera_valid(nv);
    check("basic_latency", 64'(nv - n0), 64'd12);
    entrega("basic", 64'd36, 1'b0, 0);

    // Signed: all a=-1, b=2, with backpressure while in_valid stays high.
    for (int k = 0; k < 8; k++) begin a[k] = 32'hFFFF_FFFF; b[k] = 32'd2; end
    envia_job(a, b, 0, n0);
    out_ready = 1'b0;
    espera_valid(nv);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_a = $urandom; in_b = $urandom;
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_result", out_resultado, 64'hFFFF_FFFF_FFFF_FFF0);
      @(negedge clk_i);
    end
    check("bp_bank_a0", 64'(pe_a0), 64'hFFFF_FFFF);
    check("bp_bank_b5", 64'(pe_b5), 64'd2);
    in_valid = 1'b0;
    entrega("signed", 64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 0);

    // Input gaps: a=k+1, b=8-k, valid every other cycle.
    for (int k = 0; k < 8; k++) begin a[k] = 32'(k + 1); b[k] = 32'(8 - k); end
    envia_job(a, b, 1, n0);
    espera_valid(nv);
    entrega("gaps", 64'd120, 1'b0, 0);

    // Randomized jobs against the reference sum.
    for (int j = 0; j < 6; j++) begin
      for (int k = 0; k < 8; k++) begin a[k] = $urandom; b[k] = $urandom; end
      esperado = soma_produtos(a, b);
      envia_job(a, b, 2, n0);
      espera_valid(nv);
      entrega("rand", esperado, 1'b0, int'($urandom_range(0, 3)));
    end

    // Reset mid-DISPARO, then recover with a fresh job.
    for (int k = 0; k < 8; k++) begin a[k] = $urandom; b[k] = $urandom; end
    envia_job(a, b, 0, n0);
    repeat (3) @(negedge clk_i);
    check("mid_iniciar", 64'(pe_iniciar), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mrst_iniciar", 64'(pe_iniciar), 64'd0);
    check("mrst_valid", 64'(out_valid), 64'd0);
    check("mrst_result", out_resultado, 64'd0);
    check("mrst_erro", 64'(out_erro), 64'd0);
    check("mrst_ocupado", 64'(ocupado), 64'd0);
    check("mrst_bank", 64'(pe_a2) | 64'(pe_b6), 64'd0);
    @(negedge clk_i);
    rst_n = 1'b1;
    @(negedge clk_i);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    check("post_rst_ocupado", 64'(ocupado), 64'd0);
    for (int k = 0; k < 8; k++) begin a[k] = 32'(k + 1); b[k] = 32'd1; end
    envia_job(a, b, 0, n0);
    espera_valid(nv);
    entrega("post_rst", 64'd36, 1'b0, 0);

`ifdef PRODUTO_ESCALAR_TIMEOUT_EN
    // Engine stalled: watchdog drops iniciar after 16 cycles and flags the result.
    engine_ativo = 1'b0;
    for (int k = 0; k < 8; k++) begin a[k] = $urandom; b[k] = $urandom; end
    envia_job(a, b, 0, n0);
    cnt = 0;
    while (pe_iniciar && cnt < 100) begin
      cnt++;
      @(negedge clk_i);
    end
    check("to_iniciar_cycles", 64'(cnt), 64'd16);
    espera_valid(nv);
    entrega("timeout", 64'd0, 1'b1, 2);
    engine_ativo = 1'b1;
`else
    cnt = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
